// File: rtl/tcam_pkg.sv
// Shared types and constants for the ternary CAM search engine.
// Holds the default geometry, the flush FSM state type and a constant-safe clog2.
package tcam_pkg;

    localparam int DEF_CAM_DEPTH = 16;
    localparam int DEF_CAM_WIDTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tcam_priority_encoder.sv
// Lowest-index priority encoder over the raw CAM match vector.
// Also reports whether more than one entry matched.
module tcam_priority_encoder
    import tcam_pkg::*;
#(
    parameter  int CAM_DEPTH = DEF_CAM_DEPTH,
    localparam int ADDR_W    = clog2(CAM_DEPTH)
) (
    input  logic [CAM_DEPTH-1:0] match_vector,
    output logic                 hit,
    output logic [ADDR_W-1:0]    match_addr,
    output logic                 multi_hit
);

    assign hit = |match_vector;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_hit = |(match_vector & (match_vector - CAM_DEPTH'(1)));

    always_comb begin
        match_addr = '0;
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (match_vector[i]) begin
                match_addr = ADDR_W'(i);
            end
        end
    end

endmodule

// File: rtl/tcam_search_engine.sv
// Ternary CAM with a 3-stage search pipeline (key, compare, encode) and a
// one-entry-per-cycle background flush that stalls searches and updates.
module tcam_search_engine
    import tcam_pkg::*;
#(
    parameter  int CAM_DEPTH = DEF_CAM_DEPTH,
    parameter  int CAM_WIDTH = DEF_CAM_WIDTH,
    localparam int ADDR_W    = clog2(CAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [CAM_WIDTH-1:0] wr_data,
    input  logic [CAM_WIDTH-1:0] wr_mask,
    input  logic                 inv_en,
    input  logic [ADDR_W-1:0]    inv_addr,
    input  logic                 flush_req,
    input  logic                 search_req,
    input  logic [CAM_WIDTH-1:0] search_key,
    output logic                 search_ready,
    output logic                 result_valid,
    output logic                 hit,
    output logic [ADDR_W-1:0]    match_addr,
    output logic                 multi_hit,
    output logic [CAM_DEPTH-1:0] match_vector
);

    state_t                 state;
    logic [ADDR_W-1:0]      flush_cnt;
    logic [CAM_DEPTH-1:0]   valid_q;
    logic                   ready_q;

    logic [CAM_WIDTH-1:0]   data_mem [CAM_DEPTH];
    logic [CAM_WIDTH-1:0]   mask_mem [CAM_DEPTH];

    logic [CAM_WIDTH-1:0]   key_p0;
    logic                   vld_p0;
    logic [CAM_DEPTH-1:0]   match_now;
    logic [CAM_DEPTH-1:0]   mv_p1;
    logic                   vld_p1;

    logic                   enc_hit;
    logic [ADDR_W-1:0]      enc_addr;
    logic                   enc_multi;

    assign search_ready = ready_q;

    // Control: flush FSM and valid bits. Write is applied after invalidate so it wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
            valid_q   <= '0;
            ready_q   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (inv_en) begin
                        valid_q[inv_addr] <= 1'b0;
                    end
                    if (wr_en) begin
                        valid_q[wr_addr] <= 1'b1;
                    end
                    if (flush_req) begin
                        state     <= FLUSH;
                        ready_q   <= 1'b0;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    valid_q[flush_cnt] <= 1'b0;
                    flush_cnt          <= flush_cnt + ADDR_W'(1);
                    if (flush_cnt == ADDR_W'(CAM_DEPTH - 1)) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && ready_q) begin
            data_mem[wr_addr] <= wr_data;
            mask_mem[wr_addr] <= wr_mask;
        end
    end

    // Stage 1 -> 2 boundary: compare registered key against post-edge contents.
    always_comb begin
        match_now = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            match_now[i] = valid_q[i] &&
                           (((key_p0 ^ data_mem[i]) & ~mask_mem[i]) == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (search_req && ready_q) begin
            key_p0 <= search_key;
        end
        if (vld_p0) begin
            mv_p1 <= match_now;
        end
    end

    // Stage 2 -> 3 boundary: priority-encode and register the result.
    tcam_priority_encoder #(
        .CAM_DEPTH (CAM_DEPTH)
    ) u_enc (
        .match_vector (mv_p1),
        .hit          (enc_hit),
        .match_addr   (enc_addr),
        .multi_hit    (enc_multi)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            result_valid <= 1'b0;
            hit          <= 1'b0;
            match_addr   <= '0;
            multi_hit    <= 1'b0;
            match_vector <= '0;
        end else begin
            vld_p0       <= search_req && ready_q;
            vld_p1       <= vld_p0;
            result_valid <= vld_p1;
            if (vld_p1) begin
                hit          <= enc_hit;
                match_addr   <= enc_addr;
                multi_hit    <= enc_multi;
                match_vector <= mv_p1;
            end
        end
    end

endmodule

// File: tb/tb_tcam_search_engine.sv
// Scoreboard bench for tcam_search_engine: stimulus queues expected results,
// a negedge monitor pops and compares them whenever result_valid is high.
module tb_tcam_search_engine;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [WIDTH-1:0] wr_mask = '0;
    logic             inv_en = 1'b0;
    logic [AW-1:0]    inv_addr = '0;
    logic             flush_req = 1'b0;
    logic             search_req = 1'b0;
    logic [WIDTH-1:0] search_key = '0;
    logic             search_ready;
    logic             result_valid;
    logic             hit;
    logic [AW-1:0]    match_addr;
    logic             multi_hit;
    logic [DEPTH-1:0] match_vector;

    tcam_search_engine #(
        .CAM_DEPTH (DEPTH),
        .CAM_WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_mask      (wr_mask),
        .inv_en       (inv_en),
        .inv_addr     (inv_addr),
        .flush_req    (flush_req),
        .search_req   (search_req),
        .search_key   (search_key),
        .search_ready (search_ready),
        .result_valid (result_valid),
        .hit          (hit),
        .match_addr   (match_addr),
        .multi_hit    (multi_hit),
        .match_vector (match_vector)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string tag;
        int    hit;
        int    addr;
        int    multi;
        int    mv;
        int    due;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Called in the cycle the request is driven; the result is due 3 edges later.
    task automatic expect_res(input string tag, input int h, input int a,
                              input int m, input int mv);
        exp_t e;
        e.tag   = tag;
        e.hit   = h;
        e.addr  = a;
        e.multi = m;
        e.mv    = mv;
        e.due   = cyc + 3;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst && result_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=result_valid expected=none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.tag, "_hit"},   int'(hit),          e.hit);
                chk({e.tag, "_addr"},  int'(match_addr),   e.addr);
                chk({e.tag, "_multi"}, int'(multi_hit),    e.multi);
                chk({e.tag, "_mv"},    int'(match_vector), e.mv);
                chk({e.tag, "_lat"},   cyc,                e.due);
            end
        end
    end

    task automatic do_write(input int a, input int d, input int m);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = WIDTH'(d);
        wr_mask = WIDTH'(m);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_search(input string tag, input int key, input int h,
                             input int a, input int m, input int mv);
        expect_res(tag, h, a, m, mv);
        search_req = 1'b1;
        search_key = WIDTH'(key);
        @(negedge clk);
        search_req = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sbq.size(), 0);
        sbq.delete();
        @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rv"},    int'(result_valid), 0);
        chk({tag, "_hit"},   int'(hit),          0);
        chk({tag, "_addr"},  int'(match_addr),   0);
        chk({tag, "_multi"}, int'(multi_hit),    0);
        chk({tag, "_mv"},    int'(match_vector), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(search_ready), 1);

        // Exact match
        do_write(3, 'h1234, 'h0000);
        do_search("exact", 'h1234, 1, 3, 0, 'h0008);
        wait_drain();

        // Masked entry plus exact entry: lowest index wins, multi flagged
        do_write(2, 'h12F0, 'h000F);
        do_write(5, 'h12F7, 'h0000);
        do_search("multi", 'h12F7, 1, 2, 1, 'h0024);
        wait_drain();

        // Back-to-back: hit, miss, hit, miss
        do_search("b2b0", 'h1234, 1, 3, 0, 'h0008);
        do_search("b2b1", 'hFFFF, 0, 0, 0, 'h0000);
        do_search("b2b2", 'h12F3, 1, 2, 0, 'h0004);
        do_search("b2b3", 'h0000, 0, 0, 0, 'h0000);
        wait_drain();

        // Write on the same edge as a search is visible to it
        expect_res("wr_same_edge", 1, 7, 0, 'h0080);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hABCD; wr_mask = 16'h0000;
        search_req = 1'b1; search_key = 16'hABCD;
        @(negedge clk);
        wr_en = 1'b0; search_req = 1'b0;
        wait_drain();

        // Write and invalidate to the same address: write wins
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h5555; wr_mask = 16'h0000;
        inv_en = 1'b1; inv_addr = 4'd9;
        @(negedge clk);
        wr_en = 1'b0; inv_en = 1'b0;
        do_search("wr_beats_inv", 'h5555, 1, 9, 0, 'h0200);
        wait_drain();

        // Invalidate on the same edge as a search: miss
        expect_res("inv_same_edge", 0, 0, 0, 'h0000);
        inv_en = 1'b1; inv_addr = 4'd3;
        search_req = 1'b1; search_key = 16'h1234;
        @(negedge clk);
        inv_en = 1'b0; search_req = 1'b0;
        wait_drain();

        // Flush with entries 2,5,7,9 valid; a search accepted with flush_req still sees them
        expect_res("preflush", 1, 2, 1, 'h0024);
        search_req = 1'b1; search_key = 16'h12F7; flush_req = 1'b1;
        @(negedge clk);
        search_req = 1'b0; flush_req = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("flush_ready_%0d", k), int'(search_ready), 0);
            if (k == 3) begin
                wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h0000; wr_mask = 16'hFFFF;
                flush_req = 1'b1;
            end
            if (k == 5) begin
                search_req = 1'b1; search_key = 16'h0000;
            end
            @(negedge clk);
            wr_en = 1'b0; flush_req = 1'b0; search_req = 1'b0;
        end
        chk("flush_ready_end", int'(search_ready), 1);
        wait_drain();

        do_search("post_flush0", 'h12F7, 0, 0, 0, 'h0000);
        do_search("post_flush1", 'hABCD, 0, 0, 0, 'h0000);
        do_search("post_flush2", 'h5555, 0, 0, 0, 'h0000);
        do_search("post_flush3", 'h0000, 0, 0, 0, 'h0000);
        wait_drain();

        // Reset with two searches in flight: results dropped, entries invalid
        do_write(1, 'h7777, 'h0000);
        search_req = 1'b1; search_key = 16'h7777;
        repeat (2) @(negedge clk);
        search_req = 1'b0;
        rst = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("after_reset_rv_%0d", k), int'(result_valid), 0);
        end
        chk("after_reset_ready", int'(search_ready), 1);
        do_search("after_reset0", 'h7777, 0, 0, 0, 'h0000);
        do_search("after_reset1", 'h12F7, 0, 0, 0, 'h0000);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
